// File: rtl/mul_issue_ctrl_pkg.sv
// mul_issue_ctrl_pkg: shared encodings and decode helpers for the multiply issue controller
package mul_issue_ctrl_pkg;
  localparam int XLEN = 64;
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_MULW   = 3'd4
  } op_e;
  localparam logic [1:0] SGN_SS = 2'b11;
  localparam logic [1:0] SGN_SU = 2'b10;
  localparam logic [1:0] SGN_UU = 2'b00;
  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_HOLD, S_DRAIN} state_e;
  function automatic logic [1:0] sgn_of(input logic [2:0] op);
    return op == OP_MULHSU ? SGN_SU : op == OP_MULHU ? SGN_UU : SGN_SS;
  endfunction
  function automatic logic legal_op(input logic [2:0] op);
    return op <= OP_MULW;
  endfunction
endpackage

// File: rtl/mul_issue_ctrl_if.sv
// mul_issue_ctrl_if: issue, writeback and multiplier-side signals of the issue controller
interface mul_issue_ctrl_if #(parameter int XLEN = mul_issue_ctrl_pkg::XLEN);
  logic            flush;
  logic            issue_valid;
  logic            issue_ready;
  logic [2:0]      issue_op;
  logic [XLEN-1:0] issue_rs1;
  logic [XLEN-1:0] issue_rs2;
  logic [4:0]      issue_rd;
  logic            wb_valid;
  logic            wb_ready;
  logic [XLEN-1:0] wb_data;
  logic [4:0]      wb_rd;
  logic            mul_valid;
  logic [1:0]      mul_signed;
  logic            mulw;
  logic [XLEN-1:0] mul1;
  logic [XLEN-1:0] mul2;
  logic            mul_ready;
  logic            out_valid_m;
  logic [XLEN-1:0] result_h;
  logic [XLEN-1:0] result_l;
  logic            wdog_err;
  modport master (
    input  flush, issue_valid, issue_op, issue_rs1, issue_rs2, issue_rd, wb_ready,
           mul_ready, out_valid_m, result_h, result_l,
    output issue_ready, wb_valid, wb_data, wb_rd, mul_valid, mul_signed, mulw, mul1, mul2,
           wdog_err
  );
  modport slave (
    output flush, issue_valid, issue_op, issue_rs1, issue_rs2, issue_rd, wb_ready,
           mul_ready, out_valid_m, result_h, result_l,
    input  issue_ready, wb_valid, wb_data, wb_rd, mul_valid, mul_signed, mulw, mul1, mul2,
           wdog_err
  );
endinterface

// File: rtl/mul_reuse_buf.sv
// mul_reuse_buf: single-entry store of the last 64-bit product with operand/signedness hit compare
module mul_reuse_buf #(
  parameter int XLEN = mul_issue_ctrl_pkg::XLEN,
  parameter bit EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_rs1,
  input  logic [XLEN-1:0] wr_rs2,
  input  logic [1:0]      wr_sgn,
  input  logic [XLEN-1:0] wr_h,
  input  logic [XLEN-1:0] wr_l,
  input  logic [2:0]      rd_op,
  input  logic [XLEN-1:0] rd_rs1,
  input  logic [XLEN-1:0] rd_rs2,
  output logic            hit,
  output logic [XLEN-1:0] hit_data
);
  import mul_issue_ctrl_pkg::*;
  logic            vld;
  logic [XLEN-1:0] rs1_e, rs2_e, h_e, l_e;
  logic [1:0]      sgn_e;
  // capture operands, signedness and both product halves of each completed multiply
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      vld <= 1'b0;
      rs1_e <= '0;
      rs2_e <= '0;
      sgn_e <= '0;
      h_e <= '0;
      l_e <= '0;
    end else if (wr_en) begin
      vld <= EN;
      rs1_e <= wr_rs1;
      rs2_e <= wr_rs2;
      sgn_e <= wr_sgn;
      h_e <= wr_h;
      l_e <= wr_l;
    end
  assign hit = EN && vld && legal_op(rd_op) && rd_op != OP_MULW && rs1_e == rd_rs1 &&
               rs2_e == rd_rs2 && sgn_e == sgn_of(rd_op);
  assign hit_data = rd_op == OP_MUL ? l_e : h_e;
endmodule

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: RV64M multiply issue sequencer with flush drain, result reuse and watchdog
module mul_issue_ctrl #(
  parameter int XLEN = mul_issue_ctrl_pkg::XLEN,
  parameter bit REUSE_EN = 1'b1,
  parameter int WDOG_CYCLES = 255
) (
  input logic clk,
  input logic reset,
  mul_issue_ctrl_if.master bus
);
  import mul_issue_ctrl_pkg::*;
  state_e          state, state_n;
  logic [2:0]      op_q;
  logic [XLEN-1:0] rs1_q, rs2_q, data_q, data_n, res, hit_data;
  logic [4:0]      rd_q;
  logic [7:0]      wdog_cnt;
  logic            wdog_q, hit, busy, waiting, wdog_fire, accept, done;
  assign busy = state == S_LAUNCH || state == S_WAIT || state == S_DRAIN;
  assign waiting = state == S_WAIT || state == S_DRAIN;
  assign wdog_fire = waiting && !bus.out_valid_m && wdog_cnt == 8'(WDOG_CYCLES - 1);
  assign accept = state == S_IDLE && bus.issue_valid && !bus.flush;
  assign done = state == S_WAIT && bus.out_valid_m && !bus.flush;
  assign res = op_q == OP_MUL ? bus.result_l :
               op_q == OP_MULW ? {{(XLEN-32){bus.result_l[31]}}, bus.result_l[31:0]} :
               bus.result_h;
  mul_reuse_buf #(.XLEN(XLEN), .EN(REUSE_EN)) u_reuse (
    .clk(clk),
    .reset(reset),
    .wr_en(done && op_q != OP_MULW),
    .wr_rs1(rs1_q),
    .wr_rs2(rs2_q),
    .wr_sgn(sgn_of(op_q)),
    .wr_h(bus.result_h),
    .wr_l(bus.result_l),
    .rd_op(bus.issue_op),
    .rd_rs1(bus.issue_rs1),
    .rd_rs2(bus.issue_rs2),
    .hit(hit),
    .hit_data(hit_data)
  );
  // next state and result capture; flush outranks wb_ready and issue_valid
  always_comb begin
    state_n = state;
    data_n = data_q;
    case (state)
      S_IDLE: if (accept) begin
        state_n = hit || !legal_op(bus.issue_op) ? S_HOLD : S_LAUNCH;
        data_n = hit ? hit_data : '0;
      end
      S_LAUNCH: state_n = bus.flush ? (bus.mul_ready ? S_DRAIN : S_IDLE) : bus.mul_ready ? S_WAIT : S_LAUNCH;
      S_WAIT: if (wdog_fire) state_n = S_IDLE;
        else if (bus.out_valid_m) begin
          state_n = bus.flush ? S_IDLE : S_HOLD;
          data_n = res;
        end else if (bus.flush) state_n = S_DRAIN;
      S_HOLD: state_n = bus.flush || bus.wb_ready ? S_IDLE : S_HOLD;
      S_DRAIN: state_n = bus.out_valid_m || wdog_fire ? S_IDLE : S_DRAIN;
      default: state_n = S_IDLE;
    endcase
  end
  // state, latched request, result and watchdog registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      op_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      rd_q <= '0;
      data_q <= '0;
      wdog_cnt <= '0;
      wdog_q <= 1'b0;
    end else begin
      state <= state_n;
      data_q <= data_n;
      wdog_cnt <= waiting && !bus.out_valid_m && !wdog_fire ? wdog_cnt + 8'd1 : '0;
      wdog_q <= wdog_q | wdog_fire;
      if (accept) begin
        op_q <= bus.issue_op;
        rs1_q <= bus.issue_rs1;
        rs2_q <= bus.issue_rs2;
        rd_q <= bus.issue_rd;
      end
    end
  assign bus.issue_ready = state == S_IDLE;
  assign bus.mul_valid = busy;
  assign bus.mul_signed = busy ? sgn_of(op_q) : 2'b00;
  assign bus.mulw = busy && op_q == OP_MULW;
  assign bus.mul1 = busy ? rs1_q : '0;
  assign bus.mul2 = busy ? rs2_q : '0;
  assign bus.wb_valid = state == S_HOLD;
  assign bus.wb_data = state == S_HOLD ? data_q : '0;
  assign bus.wb_rd = state == S_HOLD ? rd_q : '0;
  assign bus.wdog_err = wdog_q;
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb_mul_issue_ctrl: directed vector table plus multi-cycle corner sequences with a behavioural multiplier
module tb_mul_issue_ctrl;
  import mul_issue_ctrl_pkg::*;
  localparam int LAT = 4;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  typedef struct {
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    logic [63:0] exp;
    logic        nomul;
    logic [1:0]  sgn;
    logic        w;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int stab_bad = 0;
  logic mm_busy, mm_stall, mm_suppress;
  int mm_cnt;
  logic [63:0] mm_a, mm_b;
  logic [1:0] mm_s;
  logic mm_w;
  vec_t tv[10];
  mul_issue_ctrl_if bus();
  mul_issue_ctrl #(.XLEN(64), .REUSE_EN(1'b1), .WDOG_CYCLES(255)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [127:0] prod(input logic [63:0] a, input logic [63:0] b, input logic [1:0] s);
    logic [127:0] x, y;
    x = s[1] ? {{64{a[63]}}, a} : {64'd0, a};
    y = s[0] ? {{64{b[63]}}, b} : {64'd0, b};
    return x * y;
  endfunction
  assign bus.mul_ready = !mm_busy && !mm_stall;
  // multiplier model: LAT cycles from handshake cycle to the result pulse, checks operands stay held
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mm_busy <= 1'b0;
      mm_cnt <= 0;
      bus.out_valid_m <= 1'b0;
      bus.result_h <= '0;
      bus.result_l <= '0;
    end else if (!mm_busy) begin
      bus.out_valid_m <= 1'b0;
      if (bus.mul_valid && bus.mul_ready) begin
        mm_busy <= 1'b1;
        mm_cnt <= LAT - 1;
        mm_a <= bus.mul1;
        mm_b <= bus.mul2;
        mm_s <= bus.mul_signed;
        mm_w <= bus.mulw;
      end
    end else if (!bus.mul_valid) begin
      mm_busy <= 1'b0;
      bus.out_valid_m <= 1'b0;
    end else begin
      if (bus.mul1 !== mm_a || bus.mul2 !== mm_b || bus.mul_signed !== mm_s || bus.mulw !== mm_w)
        stab_bad <= stab_bad + 1;
      if (bus.out_valid_m) begin
        mm_busy <= 1'b0;
        bus.out_valid_m <= 1'b0;
      end else if (mm_cnt == 1 && !mm_suppress) begin
        bus.out_valid_m <= 1'b1;
        {bus.result_h, bus.result_l} <= prod(mm_a, mm_b, mm_s);
      end else if (mm_cnt > 1) mm_cnt <= mm_cnt - 1;
    end
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                       output int lat, output logic seen, output logic [1:0] sgn, output logic w);
    bus.issue_valid = 1'b1;
    bus.issue_op = op;
    bus.issue_rs1 = a;
    bus.issue_rs2 = b;
    bus.issue_rd = rd;
    @(negedge clk);
    bus.issue_valid = 1'b0;
    lat = 1;
    seen = 1'b0;
    sgn = 2'b00;
    w = 1'b0;
    while (!bus.wb_valid && lat < 400) begin
      if (bus.mul_valid && !seen) begin
        seen = 1'b1;
        sgn = bus.mul_signed;
        w = bus.mulw;
      end
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic retire();
    bus.wb_ready = 1'b1;
    @(negedge clk);
    bus.wb_ready = 1'b0;
  endtask
  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not end");
    $fatal(1);
  end
  initial begin
    int lat, n;
    logic seen, w, sawwb, early;
    logic [1:0] sgn;
    tv[0] = '{3'(OP_MULHSU), ONES, 64'd2, 5'd5, ONES, 1'b1, 2'b10, 1'b0};
    tv[1] = '{3'(OP_MUL), 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 5'd1, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 2'b11, 1'b0};
    tv[2] = '{3'(OP_MULHU), ONES, ONES, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 2'b00, 1'b0};
    tv[3] = '{3'(OP_MUL), ONES, ONES, 5'd3, 64'd1, 1'b0, 2'b11, 1'b0};
    tv[4] = '{3'(OP_MULH), ONES, ONES, 5'd6, 64'd0, 1'b1, 2'b11, 1'b0};
    tv[5] = '{3'(OP_MUL), ONES, ONES, 5'd7, 64'd1, 1'b1, 2'b11, 1'b0};
    tv[6] = '{3'(OP_MULW), 64'h7FFF_FFFF, 64'd2, 5'd8, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 2'b11, 1'b1};
    tv[7] = '{3'(OP_MULW), 64'h7FFF_FFFF, 64'd2, 5'd9, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 2'b11, 1'b1};
    tv[8] = '{3'd5, 64'd9, 64'd9, 5'd10, 64'd0, 1'b1, 2'b00, 1'b0};
    tv[9] = '{3'(OP_MULHU), ONES, ONES, 5'd11, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 2'b00, 1'b0};
    bus.flush = 1'b0;
    bus.issue_valid = 1'b0;
    bus.issue_op = '0;
    bus.issue_rs1 = '0;
    bus.issue_rs2 = '0;
    bus.issue_rd = '0;
    bus.wb_ready = 1'b0;
    mm_stall = 1'b0;
    mm_suppress = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_issue_ready", 64'(bus.issue_ready), 64'(1));
    chk("reset_wb_valid", 64'(bus.wb_valid), 64'(0));
    chk("reset_mul_valid", 64'(bus.mul_valid), 64'(0));
    chk("reset_wdog_err", 64'(bus.wdog_err), 64'(0));
    chk("reset_wb_data", bus.wb_data, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    // flush in WAIT: drained result must not reach writeback nor the reuse entry
    bus.issue_valid = 1'b1;
    bus.issue_op = OP_MULHSU;
    bus.issue_rs1 = ONES;
    bus.issue_rs2 = 64'd2;
    bus.issue_rd = 5'd4;
    @(negedge clk);
    bus.issue_valid = 1'b0;
    @(negedge clk);
    chk("wait_mul_valid", 64'(bus.mul_valid), 64'(1));
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("drain_wb_valid", 64'(bus.wb_valid), 64'(0));
    chk("drain_mul_valid", 64'(bus.mul_valid), 64'(1));
    chk("drain_mul1", bus.mul1, ONES);
    n = 0;
    sawwb = 1'b0;
    while (!bus.issue_ready && n < 50) begin
      sawwb |= bus.wb_valid;
      @(negedge clk);
      n++;
    end
    chk("drain_done", 64'(bus.issue_ready), 64'(1));
    chk("drain_no_wb", 64'(sawwb), 64'(0));
    issue(OP_MULHSU, ONES, 64'd2, 5'd4, lat, seen, sgn, w);
    chk("post_drain_miss", 64'(seen), 64'(1));
    chk("post_drain_data", bus.wb_data, ONES);
    retire();
    for (int i = 0; i < 10; i++) begin
      issue(tv[i].op, tv[i].a, tv[i].b, tv[i].rd, lat, seen, sgn, w);
      chk($sformatf("v%0d_wb_valid", i), 64'(bus.wb_valid), 64'(1));
      chk($sformatf("v%0d_wb_data", i), bus.wb_data, tv[i].exp);
      chk($sformatf("v%0d_wb_rd", i), 64'(bus.wb_rd), 64'(tv[i].rd));
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(tv[i].nomul ? 1 : LAT + 2));
      chk($sformatf("v%0d_mul_started", i), 64'(seen), 64'(!tv[i].nomul));
      chk($sformatf("v%0d_mul_dropped", i), 64'(bus.mul_valid), 64'(0));
      if (!tv[i].nomul) begin
        chk($sformatf("v%0d_mul_signed", i), 64'(sgn), 64'(tv[i].sgn));
        chk($sformatf("v%0d_mulw", i), 64'(w), 64'(tv[i].w));
      end
      chk($sformatf("v%0d_operands_stable", i), 64'(stab_bad), 64'(0));
      retire();
      chk($sformatf("v%0d_back_idle", i), 64'(bus.issue_ready), 64'(1));
    end
    // HOLD stall with a pending request, then wb_ready in the same cycle as that request
    issue(OP_MUL, 64'd6, 64'd7, 5'd12, lat, seen, sgn, w);
    bus.issue_valid = 1'b1;
    bus.issue_rs1 = 64'd2;
    bus.issue_rs2 = 64'd3;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_data", bus.wb_data, 64'd42);
      chk("hold_rd", 64'(bus.wb_rd), 64'(12));
      chk("hold_issue_ready", 64'(bus.issue_ready), 64'(0));
    end
    bus.wb_ready = 1'b1;
    @(negedge clk);
    bus.wb_ready = 1'b0;
    bus.issue_valid = 1'b0;
    chk("b2b_wb_valid", 64'(bus.wb_valid), 64'(0));
    chk("b2b_not_accepted", 64'(bus.issue_ready), 64'(1));
    // flush in HOLD beats wb_ready; flush in IDLE ignores the request
    issue(OP_MUL, 64'd6, 64'd7, 5'd12, lat, seen, sgn, w);
    chk("hit_6x7_lat", 64'(lat), 64'(1));
    bus.flush = 1'b1;
    bus.wb_ready = 1'b1;
    @(negedge clk);
    bus.wb_ready = 1'b0;
    chk("hold_flush_wb_valid", 64'(bus.wb_valid), 64'(0));
    chk("hold_flush_idle", 64'(bus.issue_ready), 64'(1));
    bus.issue_valid = 1'b1;
    bus.issue_op = OP_MUL;
    @(negedge clk);
    bus.issue_valid = 1'b0;
    bus.flush = 1'b0;
    chk("idle_flush_ignored", 64'(bus.issue_ready), 64'(1));
    chk("idle_flush_no_mul", 64'(bus.mul_valid), 64'(0));
    // flush in LAUNCH before the multiplier handshake
    mm_stall = 1'b1;
    bus.issue_valid = 1'b1;
    bus.issue_op = OP_MUL;
    bus.issue_rs1 = 64'd2;
    bus.issue_rs2 = 64'd3;
    bus.issue_rd = 5'd13;
    @(negedge clk);
    bus.issue_valid = 1'b0;
    chk("launch_mul_valid", 64'(bus.mul_valid), 64'(1));
    chk("launch_mul_signed", 64'(bus.mul_signed), 64'(3));
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("launch_flush_mul_valid", 64'(bus.mul_valid), 64'(0));
    chk("launch_flush_idle", 64'(bus.issue_ready), 64'(1));
    mm_stall = 1'b0;
    // watchdog: result never returns
    mm_suppress = 1'b1;
    bus.issue_valid = 1'b1;
    bus.issue_rd = 5'd14;
    @(negedge clk);
    bus.issue_valid = 1'b0;
    n = 0;
    sawwb = 1'b0;
    early = 1'b0;
    while (!bus.issue_ready && n < 400) begin
      @(negedge clk);
      n++;
      sawwb |= bus.wb_valid;
      if (n == 255) early = bus.wdog_err;
    end
    chk("wdog_cycles", 64'(n), 64'(256));
    chk("wdog_not_early", 64'(early), 64'(0));
    chk("wdog_err", 64'(bus.wdog_err), 64'(1));
    chk("wdog_no_wb", 64'(sawwb), 64'(0));
    chk("wdog_mul_dropped", 64'(bus.mul_valid), 64'(0));
    // async reset mid-WAIT
    bus.issue_valid = 1'b1;
    bus.issue_rd = 5'd15;
    @(negedge clk);
    bus.issue_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("wdog_sticky", 64'(bus.wdog_err), 64'(1));
    chk("wait_before_reset", 64'(bus.mul_valid), 64'(1));
    #2 reset = 1'b1;
    #1;
    chk("areset_mul_valid", 64'(bus.mul_valid), 64'(0));
    chk("areset_mul1", bus.mul1, 64'd0);
    chk("areset_issue_ready", 64'(bus.issue_ready), 64'(1));
    chk("areset_wdog_err", 64'(bus.wdog_err), 64'(0));
    chk("areset_wb_valid", 64'(bus.wb_valid), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    mm_suppress = 1'b0;
    @(negedge clk);
    issue(OP_MUL, 64'd6, 64'd7, 5'd16, lat, seen, sgn, w);
    chk("reset_clears_reuse", 64'(seen), 64'(1));
    chk("after_reset_data", bus.wb_data, 64'd42);
    retire();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
